demux8_collect: RTL and testbench
=================================

# demux8_collect

Serial-to-parallel collector: accepts one N-bit word per handshake on a single input stream and steers word k into output slot k (k = 0..7), presenting all eight slots as one frame once the eighth word lands. It is the receiving-side counterpart of the team's 8:1 mux path. A frame built here can be driven straight into `mux8` in0..in7 and read back by sweeping its 3-bit switch. It sits between a narrow producer (UART/SPI word stream) and wide parallel consumers.

## Interface
- `N`, default 1: word width in bits, ≥ 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `clear`  input  1  synchronous abort; discards the partial or complete frame.
- `in_data`  input  N  incoming word.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  collector can take a word this cycle.
- `out0`..`out7`  output  N each  frame slots; slot k holds the k-th accepted word of the frame.
- `out_valid`  output  1  all eight slots hold a complete frame.
- `out_ready`  input  1  consumer takes the frame this cycle.
- `count`  output  3  index of the next slot to be written (0..7).

## Operation
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- FSM states (shared enum):
  - **COLLECT**: `out_valid` = 0, `in_ready` = 1. Each accept writes `in_data` into slot `count`, then increments `count`. An accept with `count` = 7 wraps `count` to 0 and moves the FSM to FULL.
  - **FULL**: `out_valid` = 1. Slots are frozen. `in_ready` = `out_ready`.
    - Drain without accept → COLLECT, `count` = 0.
    - Drain with accept in the same cycle → word goes to slot 0, `count` = 1, FSM moves to COLLECT. There is no bubble between frames.
- Slots 1..7 of a new frame keep the stale values from the previous frame until they are overwritten. Consumers sample the slots only while `out_valid` = 1.
- `clear` has priority over accept and drain:
  - next state COLLECT, `count` = 0;
  - `in_ready` is forced 0 in the `clear` cycle;
  - slot contents are not zeroed.
- `count` width is fixed at 3 bits; wrap 7→0 is natural overflow.

## Timing
- Reset values: state COLLECT, `count` = 0, `out_valid` = 0, `in_ready` = 1, `out0`..`out7` all zero.
- Reset asserted mid-frame or in FULL returns to these values immediately, with no clock edge needed. The partial frame is lost.
- All outputs except `in_ready` are registered.
- `in_ready` is combinational from state, `out_ready` and `clear`. There is no combinational path from `in_valid` or `in_data`.
- Latency: `out_valid` rises on the clock edge that captures the 8th word, so it is visible 1 cycle after the accepting cycle.
- Minimum frame period is 8 cycles with `in_valid` and `out_ready` held high.
- Handshake rules:
  - Producer holds `in_data` stable while `in_valid && !in_ready`.
  - Frame and `out_valid` stay stable until drain.

## Structure
- Shared package `mux_pkg` holds:
  - `localparam SLOTS = 8`;
  - `localparam SEL_W = 3`;
  - `typedef enum logic {COLLECT, FULL} collect_state_t`.
- One sub-module: `decoder_3_to_8`. It takes `count` plus an enable and produces one-hot per-slot write enables. It is the natural inverse of the mux select tree and is reusable elsewhere.
- Slot storage is eight N-bit registers with enable, reset to 0.

## Test plan
- **Basic frame:** `N` = 8, send 0x10..0x17 back-to-back, `out_ready` = 0 → `out0`..`out7` = 0x10..0x17, `out_valid` = 1 one cycle after the 8th accept, `in_ready` = 0, `count` = 0.
- **Backpressure:** hold the full frame with `out_ready` = 0 for 5 cycles while `in_valid` = 1 and `in_data` = 0xAA → slots unchanged, no accept; on `out_ready` = 1, 0xAA is accepted into `out0`, `count` = 1, `out_valid` falls next cycle.
- **Continuous stream:** `in_valid` = `out_ready` = 1 for 24 words 0..23 → three frames (0..7, 8..15, 16..23), `out_valid` pulses every 8th cycle, no lost or duplicated word.
- **Clear:** after 3 accepts (0x01..0x03), pulse `clear` with `in_valid` = 1 → `in_ready` = 0 that cycle, `count` = 0. The next 8 words form a clean frame in slots 0..7.
- **Async reset mid-frame:** drop `rst_n` between clock edges after 5 accepts → `count`, `out_valid` and all slots go to 0 immediately. After release, a new 8-word frame completes normally.
- **Round trip:** connect `out0`..`out7` to `mux8` in0..in7 (`N` = 8), load random frame, sweep switch 0..7 → mux output equals the k-th sent word for each k.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 8-slot mux / demux datapath.
// Slot count, select width and collector state encoding.
package mux_pkg;

  localparam int SLOTS = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } collect_state_t;

  // One-hot slot mask for a select value.
  function automatic logic [SLOTS-1:0] sel_onehot(
    input logic [SEL_W-1:0] sel
  );
    logic [SLOTS-1:0] one;
    one = {{(SLOTS-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/demux8_collect_decoder.sv
// 3-to-8 one-hot decoder with enable.
// Inverse of the mux select tree; yields per-slot write strobes.
module decoder_3_to_8
  import mux_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [SLOTS-1:0] onehot_o
);

  // Gate the one-hot select with the enable.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = sel_onehot(sel_i);
    end
  end

endmodule

// File: rtl/demux8_collect.sv
// Serial-to-parallel collector: word k of a frame lands in slot k.
// Frame is presented on out0..out7 once the eighth word is stored.
module demux8_collect
  import mux_pkg::*;
#(
  parameter int N = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out0,
  output logic [N-1:0]     out1,
  output logic [N-1:0]     out2,
  output logic [N-1:0]     out3,
  output logic [N-1:0]     out4,
  output logic [N-1:0]     out5,
  output logic [N-1:0]     out6,
  output logic [N-1:0]     out7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] count
);

  collect_state_t   state_q;
  collect_state_t   state_d;
  logic [SEL_W-1:0] count_q;
  logic [SEL_W-1:0] count_d;
  logic [N-1:0]     slot_q [SLOTS];
  logic [SLOTS-1:0] wr_en;
  logic             accept;
  logic             drain;

  // Ready while collecting, or when the held frame leaves this cycle.
  always_comb begin
    in_ready = ~clear &
               ((state_q == COLLECT) | out_ready);
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == FULL);
  assign drain     = out_valid & out_ready;
  assign count     = count_q;

  // Next state and slot index; clear overrides accept and drain.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear) begin
      state_d = COLLECT;
      count_d = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            count_d = count_q + 1'b1;
            if (count_q == SEL_W'(SLOTS - 1)) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (drain) begin
            state_d = COLLECT;
            count_d = accept ? SEL_W'(1) : SEL_W'(0);
          end
        end
        default: begin
          state_d = COLLECT;
          count_d = '0;
        end
      endcase
    end
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // In FULL the index is 0, so a drain+accept write hits slot 0.
  decoder_3_to_8 u_dec (
    .sel_i    (count_q),
    .en_i     (accept),
    .onehot_o (wr_en)
  );

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    // Slot register; only the decoded slot loads on accept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q[k] <= '0;
      end else if (wr_en[k]) begin
        slot_q[k] <= in_data;
      end
    end
  end

  assign out0 = slot_q[0];
  assign out1 = slot_q[1];
  assign out2 = slot_q[2];
  assign out3 = slot_q[3];
  assign out4 = slot_q[4];
  assign out5 = slot_q[5];
  assign out6 = slot_q[6];
  assign out7 = slot_q[7];

endmodule

// File: tb/tb_demux8_collect.sv
// Self-checking bench for demux8_collect with N = 8.
// Directed scenarios plus a random run against a frame-level model.
module tb_demux8_collect;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out0, out1, out2, out3;
  logic [N-1:0] out4, out5, out6, out7;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   count;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_slot [8];
  int         m_cnt;
  bit         m_full;
  bit         exp_ready;
  bit         obs_ready;

  always #5 clk = ~clk;

  demux8_collect #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  // Behavioural 8:1 mux standing in for mux8 on the read side.
  function automatic logic [7:0] mux8_model(input int sw);
    case (sw)
      0: return out0;
      1: return out1;
      2: return out2;
      3: return out3;
      4: return out4;
      5: return out5;
      6: return out6;
      default: return out7;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_slot[k] = '0;
    m_cnt  = 0;
    m_full = 1'b0;
  endtask

  // One clock: drive, sample in_ready, clock, advance the model.
  task automatic cycle(input bit v, input logic [7:0] d,
                       input bit ord, input bit clr);
    bit acc;
    bit dr;
    in_valid  = v;
    in_data   = d;
    out_ready = ord;
    clear     = clr;
    #1;
    obs_ready = in_ready;
    exp_ready = !clr && (!m_full || ord);
    acc = v && exp_ready;
    dr  = m_full && ord;
    @(posedge clk);
    if (clr) begin
      m_cnt  = 0;
      m_full = 1'b0;
    end else begin
      if (acc) m_slot[m_cnt] = d;
      if (m_full) begin
        if (dr) begin
          m_full = 1'b0;
          m_cnt  = acc ? 1 : 0;
        end
      end else if (acc) begin
        if (m_cnt == 7) begin
          m_full = 1'b1;
          m_cnt  = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    tests++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (mux8_model(k) !== 8'h00) begin
        fails++;
        $display("FAIL reset_slot%0d got %h want 00", k, mux8_model(k));
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      tests++;
      if (out_valid !== (i == 7)) begin
        fails++;
        $display("FAIL basic_valid w%0d got %b want %b", i, out_valid, (i == 7));
      end
    end
    in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_ready got %b want 0", in_ready);
    end
    tests++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL basic_count got %0d want 0", count);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (mux8_model(k) !== 8'(8'h10 + k)) begin
        fails++;
        $display("FAIL basic_slot%0d got %h want %h", k, mux8_model(k), 8'(8'h10 + k));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      tests++;
      if (obs_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold c%0d ready %b valid %b want 0 1", c, obs_ready, out_valid);
      end
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (mux8_model(k) !== 8'(8'h10 + k)) begin
          fails++;
          $display("FAIL bp_slot%0d got %h want %h", k, mux8_model(k), 8'(8'h10 + k));
        end
      end
    end
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    tests++;
    if (obs_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready got %b want 1", obs_ready);
    end
    tests++;
    if (out0 !== 8'hAA || count !== 3'd1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release out0 %h count %0d valid %b want aa 1 0", out0, count, out_valid);
    end
    tests++;
    if (out1 !== 8'h11) begin
      fails++;
      $display("FAIL bp_stale out1 got %h want 11", out1);
    end
  endtask

  task automatic test_clear_cycle();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if (obs_ready !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle ready %b count %0d valid %b want 0 0 0", obs_ready, count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      tests++;
      if (obs_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready w%0d got %b want 1", i, obs_ready);
      end
      tests++;
      if (out_valid !== ((i % 8) == 7)) begin
        fails++;
        $display("FAIL b2b_valid w%0d got %b want %b", i, out_valid, ((i % 8) == 7));
      end
      if (out_valid === 1'b1) begin
        for (int k = 0; k < 8; k++) begin
          tests++;
          if (mux8_model(k) !== 8'(pulses * 8 + k)) begin
            fails++;
            $display("FAIL b2b_f%0d_slot%0d got %h want %h", pulses, k, mux8_model(k), 8'(pulses * 8 + k));
          end
        end
        pulses++;
      end
    end
    tests++;
    if (pulses != 3) begin
      fails++;
      $display("FAIL b2b_frames got %0d want 3", pulses);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    logic [7:0] w [8];
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    tests++;
    if (obs_ready !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL clear ready %b count %0d want 0 0", obs_ready, count);
    end
    tests++;
    if (out0 !== 8'h01) begin
      fails++;
      $display("FAIL clear_keep out0 got %h want 01", out0);
    end
    for (int i = 0; i < 8; i++) begin
      w[i] = 8'($urandom);
      cycle(1'b1, w[i], 1'b0, 1'b0);
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL clear_frame_valid got %b want 1", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (mux8_model(k) !== w[k]) begin
        fails++;
        $display("FAIL clear_slot%0d got %h want %h", k, mux8_model(k), w[k]);
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    time t0;
    logic [7:0] w [8];
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    t0 = $time;
    rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL arst count %0d valid %b want 0 0", count, out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (mux8_model(k) !== 8'h00) begin
        fails++;
        $display("FAIL arst_slot%0d got %h want 00", k, mux8_model(k));
      end
    end
    tests++;
    if ($time - t0 >= 5) begin
      fails++;
      $display("FAIL arst_timing elapsed %0t want under 5", $time - t0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w[i] = 8'($urandom);
      cycle(1'b1, w[i], 1'b0, 1'b0);
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL arst_frame_valid got %b want 1", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (mux8_model(k) !== w[k]) begin
        fails++;
        $display("FAIL arst_slot%0d got %h want %h", k, mux8_model(k), w[k]);
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_round_trip();
    logic [7:0] w [8];
    int guard;
    int i;
    i = 0;
    guard = 0;
    while (i < 8 && guard < 100) begin
      w[i] = 8'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        cycle(1'b1, w[i], 1'b0, 1'b0);
        i++;
      end else begin
        cycle(1'b0, 8'hEE, 1'b0, 1'b0);
      end
      guard++;
    end
    tests++;
    if (i != 8 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rt_load words %0d valid %b want 8 1", i, out_valid);
    end
    for (int sw = 0; sw < 8; sw++) begin
      tests++;
      if (mux8_model(sw) !== w[sw]) begin
        fails++;
        $display("FAIL rt_sw%0d got %h want %h", sw, mux8_model(sw), w[sw]);
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
      tests++;
      if (obs_ready !== exp_ready) begin
        fails++;
        $display("FAIL rnd_ready c%0d got %b want %b", c, obs_ready, exp_ready);
      end
      tests++;
      if (out_valid !== m_full || count !== 3'(m_cnt)) begin
        fails++;
        $display("FAIL rnd_state c%0d valid %b count %0d want %b %0d", c, out_valid, count, m_full, m_cnt);
      end
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (mux8_model(k) !== m_slot[k]) begin
          fails++;
          $display("FAIL rnd_slot%0d c%0d got %h want %h", k, c, mux8_model(k), m_slot[k]);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_clear_cycle();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_round_trip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
